// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// seq_divider : multi-cycle radix-2 restoring divider, signed/unsigned, with
// valid/ready handshake. Optional macro DIV_REM_EN builds the remainder output.
// Revision 1.0
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] rn,
  input  logic [WIDTH-1:0] rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             dz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic             accept;
  logic             last_step;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic             q_neg;
  logic             ovf_pend;

  logic             rn_neg;
  logic             rm_neg;
  logic             rm_zero;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] prem_nx;
  logic [WIDTH-1:0] dvd_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = rm_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (count == '0) begin
          last_step = 1'b1;
          state_nx  = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand signs only matter in signed mode; unsigned operands are taken raw.
  assign rn_neg  = ~mode & rn[WIDTH-1];
  assign rm_neg  = ~mode & rm[WIDTH-1];
  assign rm_zero = (rm == '0);

  // One restoring step: the shifted partial remainder needs WIDTH+1 bits
  // because an unsigned divisor may use the full WIDTH.
  assign shifted = {prem, dvd[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign q_bit   = ~diff[WIDTH];
  assign prem_nx = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign dvd_nx  = {dvd[WIDTH-2:0], q_bit};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      dvd      <= '0;
      dvs      <= '0;
      prem     <= '0;
      q_neg    <= 1'b0;
      ovf_pend <= 1'b0;
      quot     <= '0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      count    <= CNT_INIT;
      dvd      <= rn_neg ? -rn : rn;
      dvs      <= rm_neg ? -rm : rm;
      prem     <= '0;
      q_neg    <= rn_neg ^ rm_neg;
      ovf_pend <= rn_neg && (rn == MIN_VAL) && (&rm);
      dz       <= rm_zero;
      ovf      <= 1'b0;
      if (rm_zero) quot <= '1;
    end else if (state == S_CALC) begin
      dvd  <= dvd_nx;
      prem <= prem_nx;
      if (count != '0) count <= count - 1'b1;
      if (last_step) begin
        quot <= q_neg ? -dvd_nx : dvd_nx;
        ovf  <= ovf_pend;
      end
    end
  end

`ifdef DIV_REM_EN
  logic r_neg;

  // Remainder follows the dividend's sign; divide-by-zero returns rn itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_neg <= 1'b0;
      rem   <= '0;
    end else if (accept) begin
      r_neg <= rn_neg;
      if (rm_zero) rem <= rn;
    end else if (last_step) begin
      rem <= r_neg ? -prem_nx : prem_nx;
    end
  end
`else
  assign rem = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// tb_seq_divider : directed self-checking bench for seq_divider (WIDTH=32).
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         mode = 1'b0;
  logic [W-1:0] rn = '0;
  logic [W-1:0] rm = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         dz;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .rn        (rn),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .dz        (dz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Expected remainder as seen on the port for this build.
  function automatic logic [W-1:0] exp_rem(input logic [W-1:0] r);
`ifdef DIV_REM_EN
    return r;
`else
    return '0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request while idle; returns just after the accept edge.
  task automatic accept_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    mode = m; rn = a; rm = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0; rn = '0; rm = '0; mode = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (quot !== '0 || rem !== '0) begin bad++; $display("FAIL reset_data: quot=%h rem=%h want 0/0", quot, rem); end
    total++; if (dz !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL reset_flags: dz=%b ovf=%b want 0/0", dz, ovf); end
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_signed();
    logic [W-1:0] va [4] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'hFFFF_FF9C, 32'h0000_0000};
    logic [W-1:0] vb [4] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'h0000_0005};
    logic [W-1:0] eq [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h0000_000E, 32'h0000_0000};
    logic [W-1:0] er [4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0000};
    int lat;
    for (int i = 0; i < 4; i++) begin
      accept_op(1'b0, va[i], vb[i]);
      wait_valid(lat);
      total++; if (lat !== W) begin bad++; $display("FAIL signed_latency[%0d]: got %0d want %0d", i, lat, W); end
      total++; if (quot !== eq[i]) begin bad++; $display("FAIL signed_quot[%0d]: got %h want %h", i, quot, eq[i]); end
      total++; if (rem !== exp_rem(er[i])) begin bad++; $display("FAIL signed_rem[%0d]: got %h want %h", i, rem, exp_rem(er[i])); end
      total++; if (dz !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL signed_flags[%0d]: dz=%b ovf=%b want 0/0", i, dz, ovf); end
      take_result();
    end
  endtask

  task automatic test_unsigned();
    logic [W-1:0] va [3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] vb [3] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h0001_0000};
    logic [W-1:0] eq [3] = '{32'h7FFF_FFFC, 32'h0000_0000, 32'h0000_FFFF};
    logic [W-1:0] er [3] = '{32'h0000_0001, 32'h8000_0000, 32'h0000_FFFF};
    int lat;
    for (int i = 0; i < 3; i++) begin
      accept_op(1'b1, va[i], vb[i]);
      wait_valid(lat);
      total++; if (lat !== W) begin bad++; $display("FAIL unsigned_latency[%0d]: got %0d want %0d", i, lat, W); end
      total++; if (quot !== eq[i]) begin bad++; $display("FAIL unsigned_quot[%0d]: got %h want %h", i, quot, eq[i]); end
      total++; if (rem !== exp_rem(er[i])) begin bad++; $display("FAIL unsigned_rem[%0d]: got %h want %h", i, rem, exp_rem(er[i])); end
      total++; if (dz !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL unsigned_flags[%0d]: dz=%b ovf=%b want 0/0", i, dz, ovf); end
      take_result();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    accept_op(1'b0, 32'd100, 32'd0);
    wait_valid(lat);
    total++; if (lat !== 0) begin bad++; $display("FAIL dz_latency: got %0d want 0", lat); end
    total++; if (quot !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_quot: got %h want ffffffff", quot); end
    total++; if (rem !== exp_rem(32'd100)) begin bad++; $display("FAIL dz_rem: got %h want %h", rem, exp_rem(32'd100)); end
    total++; if (dz !== 1'b1 || ovf !== 1'b0) begin bad++; $display("FAIL dz_flags: dz=%b ovf=%b want 1/0", dz, ovf); end
    take_result();
  endtask

  task automatic test_overflow();
    int lat;
    accept_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_valid(lat);
    total++; if (lat !== W) begin bad++; $display("FAIL ovf_latency: got %0d want %0d", lat, W); end
    total++; if (quot !== 32'h8000_0000) begin bad++; $display("FAIL ovf_quot: got %h want 80000000", quot); end
    total++; if (rem !== '0) begin bad++; $display("FAIL ovf_rem: got %h want 0", rem); end
    total++; if (ovf !== 1'b1 || dz !== 1'b0) begin bad++; $display("FAIL ovf_flags: dz=%b ovf=%b want 0/1", dz, ovf); end
    take_result();
  endtask

  task automatic test_backpressure();
    int lat;
    accept_op(1'b1, 32'd1000, 32'd7);
    wait_valid(lat);
    total++; if (lat !== W) begin bad++; $display("FAIL bp_latency: got %0d want %0d", lat, W); end
    mode = 1'b1; rn = 32'd55; rm = 32'd5; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready); end
      total++; if (quot !== 32'd142 || rem !== exp_rem(32'd6)) begin bad++; $display("FAIL bp_data[%0d]: quot=%h rem=%h want %h/%h", i, quot, rem, 32'd142, exp_rem(32'd6)); end
    end
    in_valid = 1'b0; rn = '0; rm = '0;
    take_result();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_no_pending: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    accept_op(1'b1, 32'd1000, 32'd7);
    for (int i = 0; i < 10; i++) step();
    reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || quot !== '0) begin bad++; $display("FAIL midreset_state: out_valid=%b in_ready=%b quot=%h want 0/1/0", out_valid, in_ready, quot); end
    step();
    reset_n = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_stale: out_valid=%b want 0", out_valid); end
    accept_op(1'b1, 32'd9, 32'd3);
    wait_valid(lat);
    total++; if (lat !== W) begin bad++; $display("FAIL midreset_latency: got %0d want %0d", lat, W); end
    total++; if (quot !== 32'd3 || rem !== '0) begin bad++; $display("FAIL midreset_result: quot=%h rem=%h want 3/0", quot, rem); end
    take_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    accept_op(1'b1, 32'd50, 32'd5);
    wait_valid(lat);
    total++; if (lat !== W || quot !== 32'd10) begin bad++; $display("FAIL b2b_first: lat=%0d quot=%h want %0d/a", lat, quot, W); end
    mode = 1'b0; rn = 32'hFFFF_FFF7; rm = 32'd4; in_valid = 1'b1;
    step();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    step();
    in_valid = 1'b0; rn = '0; rm = '0;
    wait_valid(lat);
    total++; if (lat !== W) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", lat, W); end
    total++; if (quot !== 32'hFFFF_FFFE || rem !== exp_rem(32'hFFFF_FFFF)) begin bad++; $display("FAIL b2b_second: quot=%h rem=%h want fffffffe/%h", quot, rem, exp_rem(32'hFFFF_FFFF)); end
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
